correlation_sequencer: RTL
==========================

// Module: correlation_sequencer
// PURPOSE
//  Time-multiplexes ONE multiplication_unit over the two mismatch passes per chunk:
//    pass A = pattern x ~data, pass B = ~pattern x data.
//  ORs the two results, merges the tail of the previous chunk and scans for zero lags.
//  Accumulates a saturating match count for the LED display.
//  Sits between serial (chunk source) and ledDisplay; replaces the dual-instance, k-delay sequencing.
// PARAMETERS
//  N       30  chunk/pattern width in bits
//  SETTLE  32  cycles from mu_start to stable mu_result (must be >=1)
//  CNT_W   16  match counter width
// PORTS
//  clk           in   1      system clock
//  reset         in   1      asynchronous, active-high reset
//  stream_start  in   1      1-cycle pulse: latch pattern_in, clear count, arm stream
//  stream_end    in   1      1-cycle pulse: stop accepting chunks after current one
//  pattern_in    in   N      pattern (already bit-reversed by the producer)
//  chunk_valid   in   1      1-cycle pulse: chunk_data holds a new chunk
//  chunk_data    in   N      data chunk from serial
//  chunk_ready   out  1      high only in IDLE while stream armed
//  mu_a          out  N      multiplication_unit operand A
//  mu_b          out  N      multiplication_unit operand B
//  mu_start      out  1      1-cycle launch strobe to multiplication_unit
//  mu_result     in   2N     multiplication_unit product; bit k=1 -> mismatch at lag k
//  match_count   out  CNT_W  running matches in stream, saturates at all-ones
//  match_valid   out  1      1-cycle pulse: match_count updated for a chunk
//  busy          out  1      high in any state other than IDLE
//  overrun       out  1      sticky: chunk_valid seen while chunk_ready low and armed
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE, armed=0, prev_tail=all-ones, registers cleared.
//  FSM: IDLE -> LOAD_A -> WAIT_A -> LOAD_B -> WAIT_B -> SCAN -> DONE -> IDLE.
//   IDLE: chunk_valid & armed -> latch chunk_data into dreg, go LOAD_A (cycle 0).
//   LOAD_A (1 cyc): mu_a=pat, mu_b=~dreg, mu_start=1.
//   WAIT_A (SETTLE cyc): hold operands; last cycle captures rA = mu_result.
//   LOAD_B (1 cyc): mu_a=~pat, mu_b=dreg, mu_start=1.
//   WAIT_B (SETTLE cyc): last cycle captures rB; C = rA | rB.
//   SCAN (N cyc): o=1..N, one lag per cycle. M[o] = C[o] | prev_tail[o] for o<N;
//    M[N] = C[N]. M[o]==0 -> cnt+1, saturating.
//   DONE (1 cyc): match_valid=1; prev_tail[o] <= C[o+N] for o=1..N-1.
//  Operands are held constant between mu_start pulses; mu_a/mu_b are 0 in IDLE.
//  Latency: chunk accepted at cycle 0 -> match_valid at cycle 2*SETTLE+N+3.
//  stream_start (any state): abort to IDLE, pat<=pattern_in, cnt<=0, overrun<=0,
//   prev_tail<=all-ones (partial windows before stream start never match), armed<=1.
//  stream_end: armed<=0; an in-flight chunk completes and still pulses match_valid.
//  Simultaneous stream_start & stream_end: stream_start wins.
//  Simultaneous chunk_valid & stream_start: chunk dropped, no overrun.
//  chunk_valid with armed=0: ignored, no overrun.
//  Counter saturation: stays at 2^CNT_W-1; match_valid still pulses.
//  Reset asserted mid-operation: immediate return to reset values; mu_start low.
// STRUCTURE
//  corr_pkg: state encoding localparams (IDLE..DONE) and the N/SETTLE defaults,
//   shared with serial and multiplication_unit wrappers.
//  Sub-module lag_scanner: the SCAN walker; inputs C, prev_tail and go;
//   outputs inc pulse and done. FSM, timer and counter stay in the top.
// TESTING  (bench: N=4, SETTLE=3, behavioural multiplication_unit model)
//  1 reset mid-WAIT_B -> all outputs 0 same cycle; next chunk ignored until stream_start.
//  2 start pat=4'b1011, chunk=4'b1011, model C=0 at lag 4
//    -> mu_start at cycles 1 and 5; match_valid at cycle 13; match_count=1.
//  3 two chunks whose match spans the boundary (prev C[5]=0, cur C[1]=0)
//    -> second chunk counts the lag-1 match; first chunk's partial window not counted.
//  4 chunk_valid at cycle 4 of busy chunk -> dropped; overrun=1 until next stream_start.
//  5 preload cnt=16'hFFFE, chunk with 3 zero lags -> match_count=16'hFFFF, match_valid pulses.
//  6 stream_end during SCAN -> match_valid still pulses; later chunk_valid ignored;
//    chunk_ready stays 0.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared encodings and default geometry for the correlation datapath
// (sequencer, serial and multiplication_unit wrappers).
package corr_pkg;

    localparam int N_DEF      = 30;
    localparam int SETTLE_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        WAIT_A = 3'd2,
        LOAD_B = 3'd3,
        WAIT_B = 3'd4,
        SCAN   = 3'd5,
        DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/correlation_sequencer_lag_scanner.sv
// Walks lags 1..N of the merged mismatch map, one lag per cycle while go
// is high, pulsing inc for every lag whose window has no mismatch.
module lag_scanner
    import corr_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic [N:1]   c,
    input  logic [N-1:1] prev_tail,
    output logic         inc,
    output logic         done
);

    localparam int OW = $clog2(N + 1);
    localparam logic [OW-1:0] LAST = OW'(N);

    logic [OW-1:0] lag;
    logic [N:1]    m;

    // Partial windows also need the previous chunk's tail to be clean.
    always_comb begin
        m = c;
        m[N-1:1] = c[N-1:1] | prev_tail;
    end

    assign done = go && (lag == LAST);
    assign inc  = go && !m[lag];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lag <= OW'(1);
        end else if (go && !done) begin
            lag <= lag + 1'b1;
        end else begin
            lag <= OW'(1);
        end
    end

endmodule

// File: rtl/correlation_sequencer.sv
// Runs both mismatch passes of a chunk through one shared multiplier,
// merges them with the previous chunk's tail and counts zero lags.
module correlation_sequencer
    import corr_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int SETTLE = SETTLE_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stream_start,
    input  logic             stream_end,
    input  logic [N-1:0]     pattern_in,
    input  logic             chunk_valid,
    input  logic [N-1:0]     chunk_data,
    output logic             chunk_ready,
    output logic [N-1:0]     mu_a,
    output logic [N-1:0]     mu_b,
    output logic             mu_start,
    input  logic [2*N-1:0]   mu_result,
    output logic [CNT_W-1:0] match_count,
    output logic             match_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int TW = $clog2(SETTLE + 1);
    localparam logic [TW-1:0] TLAST = TW'(SETTLE - 1);

    state_t           state;
    state_t           state_nx;
    logic             armed;
    logic [N-1:0]     pat;
    logic [N-1:0]     dreg;
    logic [2*N-1:1]   ra;
    logic [2*N-1:1]   c;
    logic [N-1:1]     prev_tail;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [TW-1:0]    timer;
    logic             tlast;
    logic             waiting;
    logic             accept;
    logic             scan_inc;
    logic             scan_done;
    logic             unused_lag0;

    // Lag 0 cannot occur in the product placement.
    assign unused_lag0 = mu_result[0];

    assign tlast   = timer == TLAST;
    assign waiting = (state == WAIT_A) || (state == WAIT_B);
    assign accept  = (state == IDLE) && chunk_valid && armed && !stream_start;

    assign busy        = state != IDLE;
    assign chunk_ready = (state == IDLE) && armed;
    assign match_count = cnt;

    lag_scanner #(
        .N(N)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .go       (state == SCAN),
        .c        (c[N:1]),
        .prev_tail(prev_tail),
        .inc      (scan_inc),
        .done     (scan_done)
    );

    always_comb begin
        state_nx    = state;
        mu_a        = '0;
        mu_b        = '0;
        mu_start    = 1'b0;
        match_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = LOAD_A;
            end
            LOAD_A: begin
                mu_a     = pat;
                mu_b     = ~dreg;
                mu_start = 1'b1;
                state_nx = WAIT_A;
            end
            WAIT_A: begin
                mu_a = pat;
                mu_b = ~dreg;
                if (tlast) state_nx = LOAD_B;
            end
            LOAD_B: begin
                mu_a     = ~pat;
                mu_b     = dreg;
                mu_start = 1'b1;
                state_nx = WAIT_B;
            end
            WAIT_B: begin
                mu_a = ~pat;
                mu_b = dreg;
                if (tlast) state_nx = SCAN;
            end
            SCAN: begin
                mu_a = ~pat;
                mu_b = dreg;
                if (scan_done) state_nx = DONE;
            end
            DONE: begin
                mu_a        = ~pat;
                mu_b        = dreg;
                match_valid = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (stream_start) state_nx = IDLE;
    end

    always_comb begin
        cnt_nx = cnt;
        if (scan_inc && (cnt != '1)) cnt_nx = cnt + 1'b1;
        if (stream_start) cnt_nx = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            armed     <= 1'b0;
            pat       <= '0;
            dreg      <= '0;
            ra        <= '0;
            c         <= '0;
            prev_tail <= '1;
            cnt       <= '0;
            timer     <= '0;
            overrun   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            timer <= (waiting && !tlast) ? timer + 1'b1 : '0;
            if (accept) dreg <= chunk_data;
            if (state == WAIT_A && tlast) ra <= mu_result[2*N-1:1];
            if (state == WAIT_B && tlast) c <= ra | mu_result[2*N-1:1];
            if (state == DONE) prev_tail <= c[2*N-1:N+1];
            if (chunk_valid && armed && state != IDLE && !stream_start)
                overrun <= 1'b1;
            if (stream_start) begin
                pat       <= pattern_in;
                overrun   <= 1'b0;
                prev_tail <= '1;
                armed     <= 1'b1;
            end else if (stream_end) begin
                armed <= 1'b0;
            end
        end
    end

endmodule
